// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory write side (loader) and fetch side.
package imem_pkg;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam int unsigned IMEM_DEPTH_BYTES = 24;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StCollect,
    StWrite,
    StFinish
  } state_e;

  // True when a load request cannot be honoured. The end address is formed at 33 bits so a
  // base near the top of the address space cannot wrap past the depth check.
  function automatic logic req_invalid(input logic [31:0] base, input logic [15:0] len,
                                       input int unsigned depth);
    logic [32:0] end_addr;
    end_addr = {1'b0, base} + {17'd0, len};
    return (base[1:0] != 2'b00) || (len == 16'd0) || (len[1:0] != 2'b00) ||
           (end_addr > 33'(depth));
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into little-endian 32-bit words; first byte lands in bits [7:0].
module byte_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic [7:0]  data_i,
  output logic [31:0] word_o,
  output logic        full_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (push_i) begin
      word_d[{cnt_q, 3'b000} +: 8] = data_i;
      cnt_d = cnt_q + 2'd1;
    end
  end

  // Asserted in the cycle whose push completes the word.
  assign full_o = push_i && (cnt_q == 2'd3);
  assign word_o = word_q;

endmodule

// File: rtl/imem_loader.sv
// Streams bytes from a host into instruction memory as consecutive little-endian word writes.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = imem_pkg::IMEM_DEPTH_BYTES,
  parameter int unsigned CSUM_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic [15:0]       length,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CSUM_W-1:0] checksum
);

  state_e              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [15:0]         rem_q, rem_d;
  logic [CSUM_W-1:0]   csum_q, csum_d;
  logic                err_q, err_d;
  logic                pk_clear, pk_push, pk_full;
  logic [31:0]         pk_word;

  byte_packer u_byte_packer (
    .clk_i   (clock),
    .rst_i   (reset),
    .clear_i (pk_clear),
    .push_i  (pk_push),
    .data_i  (in_data),
    .word_o  (pk_word),
    .full_o  (pk_full)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      csum_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      csum_q  <= csum_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    csum_d   = csum_q;
    err_d    = err_q;
    pk_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d   = base_addr;
          rem_d    = length;
          csum_d   = '0;
          err_d    = 1'b0;
          pk_clear = 1'b1;
          state_d  = StCheck;
        end
      end
      StCheck: begin
        if (req_invalid(addr_q, rem_q, DEPTH_BYTES)) begin
          err_d   = 1'b1;
          state_d = StFinish;
        end else begin
          state_d = StCollect;
        end
      end
      StCollect: begin
        if (pk_push) csum_d = csum_q + CSUM_W'(in_data);
        if (pk_full) state_d = StWrite;
      end
      StWrite: begin
        addr_d   = addr_q + 32'(INSTR_BYTES);
        rem_d    = rem_q - 16'(INSTR_BYTES);
        pk_clear = 1'b1;
        state_d  = (rem_q == 16'(INSTR_BYTES)) ? StFinish : StCollect;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Strobes are masked during reset so a write or byte transfer in that cycle never happens.
  always_comb begin
    in_ready = (state_q == StCollect) && !reset;
    mem_we   = (state_q == StWrite) && !reset;
    done     = (state_q == StFinish) && !reset;
    err      = done && err_q;
    busy     = (state_q == StCheck) || (state_q == StCollect) || (state_q == StWrite);
  end

  assign pk_push   = in_ready && in_valid;
  assign mem_addr  = addr_q;
  assign mem_wdata = pk_word;
  assign checksum  = csum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader checked against a word-level model of the load rules.
module tb_imem_loader;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] length;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] checksum;

  imem_loader dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .checksum  (checksum)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  int          vectors    = 0;
  int          miscompares = 0;
  int          cyc        = 0;
  int          done_cnt   = 0;
  int          exp_done   = 0;
  logic        rdy_prev   = 1'b0;
  wr_t         wr_q[$];
  int          rdy_q[$];
  logic [7:0]  stim_q[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (mem_we === 1'b1) wr_q.push_back('{addr: mem_addr, data: mem_wdata, cyc: cyc});
    if (in_ready === 1'b1 && !rdy_prev) rdy_q.push_back(cyc);
    rdy_prev <= (in_ready === 1'b1);
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit load_ok(input logic [31:0] b, input logic [15:0] len);
    longint e;
    e = longint'(b) + longint'(len);
    return (b % 4 == 0) && (len != 0) && (len % 4 == 0) && (e <= 24);
  endfunction

  function automatic logic [31:0] exp_word(input int k);
    return 32'(stim_q[4*k]) | (32'(stim_q[4*k+1]) << 8) | (32'(stim_q[4*k+2]) << 16) |
           (32'(stim_q[4*k+3]) << 24);
  endfunction

  task automatic fill_random(input int n);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
  endtask

  task automatic check_writes(input int wr0, input int n_exp, input logic [31:0] b,
                              input int acc4[$]);
    chk("wr_count", 64'(wr_q.size() - wr0), 64'(n_exp));
    for (int k = 0; k < n_exp && (wr0 + k) < wr_q.size(); k++) begin
      chk("wr_addr", wr_q[wr0 + k].addr, b + 32'(4 * k));
      chk("wr_data", wr_q[wr0 + k].data, exp_word(k));
      if (k < acc4.size()) chk("wr_timing", 64'(wr_q[wr0 + k].cyc), 64'(acc4[k] + 1));
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_load(input logic [31:0] b, input logic [15:0] len, input int nbytes,
                          input bit gaps, input bit glitch, input int rst_idx);
    int         idx = 0;
    int         wr0 = wr_q.size();
    int         rdy0 = rdy_q.size();
    int         acc4[$];
    int         start_cyc;
    bit         ok = load_ok(b, len);
    bit         got_done = 1'b0;
    bit         glitched = 1'b0;
    logic [15:0] exp_sum = '0;
    if (ok) for (int i = 0; i < int'(len); i++) exp_sum += 16'(stim_q[i]);
    start = 1'b1; base_addr = b; length = len; start_cyc = cyc;
    @(posedge clock); #1;
    base_addr = $urandom; length = 16'($urandom);
    for (int t = 0; t < 600; t++) begin
      start = 1'b0;
      if (glitch && idx == 2 && !glitched) begin
        start = 1'b1; base_addr = b + 32'd8; length = 16'd4; glitched = 1'b1;
      end
      if (rst_idx >= 0 && idx == rst_idx) reset = 1'b1;
      in_valid = (idx < nbytes) && (!gaps || $urandom_range(0, 2) != 0);
      in_data  = in_valid ? stim_q[idx] : 8'($urandom);
      @(negedge clock);
      if (reset) begin
        chk("rst_cycle_ready", in_ready, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_checksum", checksum, 16'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        #1;
        check_writes(wr0, rst_idx / 4, b, acc4);
        @(posedge clock); #1;
        return;
      end
      if (in_valid && in_ready) begin
        if (idx % 4 == 3) acc4.push_back(cyc);
        idx++;
      end
      if (done === 1'b1) begin
        got_done = 1'b1;
        #1;
        exp_done++;
        chk("done_count", 64'(done_cnt), 64'(exp_done));
        chk("err", err, !ok);
        chk("busy_at_done", busy, 1'b0);
        chk("checksum", checksum, exp_sum);
        check_writes(wr0, ok ? int'(len) / 4 : 0, b, acc4);
        if (ok) begin
          if (wr_q.size() > wr0) chk("done_latency", 64'(cyc), 64'(wr_q[$].cyc + 1));
          chk("ready_seen", 64'(rdy_q.size() > rdy0), 64'd1);
          if (rdy_q.size() > rdy0) chk("ready_latency", 64'(rdy_q[rdy0]), 64'(start_cyc + 2));
        end else begin
          chk("err_latency", 64'(cyc), 64'(start_cyc + 2));
          chk("no_ready", 64'(rdy_q.size() - rdy0), 64'd0);
        end
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
      if (got_done) break;
    end
    if (!got_done) chk("done_timeout", 64'(got_done), 64'd1);
  endtask

  initial begin
    logic [31:0] rb;
    logic [15:0] rl;
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_in_ready", in_ready, 1'b0);
    chk("reset_mem_we", mem_we, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_checksum", checksum, 16'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Two-instruction program, stream never stalls.
    stim_q = '{8'h33, 8'h03, 8'h94, 8'h00, 8'hb3, 8'h83, 8'h29, 8'h41};
    run_load(32'd0, 16'd8, 8, 1'b0, 1'b0, -1);

    // Full memory with random gaps.
    fill_random(24);
    run_load(32'd0, 16'd24, 24, 1'b1, 1'b0, -1);

    // Rejected requests.
    fill_random(8);
    run_load(32'd2, 16'd4, 4, 1'b0, 1'b0, -1);
    run_load(32'd20, 16'd8, 8, 1'b0, 1'b0, -1);
    run_load(32'd0, 16'd6, 6, 1'b0, 1'b0, -1);

    // Reset after two bytes of the second word, then a clean reload.
    fill_random(8);
    run_load(32'd0, 16'd8, 8, 1'b1, 1'b0, 6);
    fill_random(8);
    run_load(32'd4, 16'd8, 8, 1'b1, 1'b0, -1);

    // A start pulse mid-load must be ignored.
    fill_random(16);
    run_load(32'd0, 16'd16, 16, 1'b1, 1'b1, -1);

    // Back-to-back loads.
    fill_random(12);
    run_load(32'd8, 16'd12, 12, 1'b0, 1'b0, -1);
    fill_random(8);
    run_load(32'd12, 16'd8, 8, 1'b1, 1'b0, -1);

    // Random requests, valid or not.
    for (int i = 0; i < 10; i++) begin
      rb = 32'($urandom_range(0, 6) * 4 + (($urandom_range(0, 3) == 0) ? 1 : 0));
      rl = 16'($urandom_range(0, 4) * 4 + (($urandom_range(0, 4) == 0) ? 2 : 0));
      fill_random(load_ok(rb, rl) ? int'(rl) : 4);
      run_load(rb, rl, load_ok(rb, rl) ? int'(rl) : 4, 1'b1, 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
